// File: rtl/mont_mult_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mont_mult_arbiter_if: requester and montgomery-core bus of the arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mont_mult_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 381
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*WIDTH-1:0] req_m;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_err;
  logic                  core_start;
  logic [WIDTH-1:0]      core_a;
  logic [WIDTH-1:0]      core_b;
  logic [WIDTH-1:0]      core_m;
  logic                  core_done;
  logic [WIDTH-1:0]      core_result;
  logic                  busy;
  logic [2:0]            grant_id;

  modport slave (
    input  req_valid, req_a, req_b, req_m, core_done, core_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, core_start,
           core_a, core_b, core_m, busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, req_m, core_done, core_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, core_start,
           core_a, core_b, core_m, busy, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/mont_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mont_mult_arbiter: round-robin sharing of one montgomery core by NREQ      |
// | requesters. Optional WAIT watchdog enabled by MONT_ARB_WATCHDOG_EN.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mont_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 381,
  parameter int TIMEOUT = 4096
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  mont_mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("mont_mult_arbiter: NREQ must be 2..8 and TIMEOUT must be positive");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_rr_ptr;
  logic [2:0]       r_grant_id;
  logic [2:0]       w_gnt;
  logic             w_found;
  logic             w_accept;
  logic             w_capture;
  logic             w_expire;
  logic             w_timeout;
  logic             w_core_start;
  logic [NREQ-1:0]  w_req_ready;
  logic [NREQ-1:0]  w_rsp_valid;
  logic [7:0]       w_valid8;
  logic [WIDTH-1:0] r_core_a;
  logic [WIDTH-1:0] r_core_b;
  logic [WIDTH-1:0] r_core_m;
  logic [WIDTH-1:0] r_rsp_result;
  logic [WIDTH-1:0] w_a [8];
  logic [WIDTH-1:0] w_b [8];
  logic [WIDTH-1:0] w_m [8];

  // Unused lanes are zero so a 3-bit grant index never needs a range check.
  for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
    if (gi < NREQ) begin : g_live
      assign w_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign w_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
      assign w_m[gi] = bus.req_m[gi*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_a[gi] = '0;
      assign w_b[gi] = '0;
      assign w_m[gi] = '0;
    end
  end

  assign w_valid8 = 8'(bus.req_valid);

  function automatic logic [2:0] f_wrap(input logic [2:0] base, input logic [2:0] ofs);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, ofs};
    if (s >= 4'(NREQ)) s = s - 4'(NREQ);
    return s[2:0];
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_valid8[f_wrap(r_rr_ptr, 3'(k))]) begin
        w_found = 1'b1;
        w_gnt   = f_wrap(r_rr_ptr, 3'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    w_core_start = 1'b0;
    w_req_ready  = '0;
    w_rsp_valid  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept    = 1'b1;
          w_req_ready = NREQ'(8'd1 << w_gnt);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_core_start = 1'b1;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving together with the timeout still counts as success.
        if (bus.core_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_expire    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = NREQ'(8'd1 << r_grant_id);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_core_m     <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_core_a   <= w_a[w_gnt];
        r_core_b   <= w_b[w_gnt];
        r_core_m   <= w_m[w_gnt];
        r_grant_id <= w_gnt;
      end
      if (r_state == S_RESP)
        r_rr_ptr <= (r_grant_id == 3'(NREQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
      if (w_capture)     r_rsp_result <= bus.core_result;
      else if (w_expire) r_rsp_result <= '0;
    end
  end

`ifdef MONT_ARB_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_rsp_err;

  // Counter holds the number of WAIT cycles already elapsed.
  assign w_timeout = ((r_wd_cnt + 32'd1) == 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wd_cnt  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wd_cnt <= '0;
      else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_capture || w_expire)  r_rsp_err <= w_expire;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.core_start = w_core_start;
  assign bus.core_a     = r_core_a;
  assign bus.core_b     = r_core_b;
  assign bus.core_m     = r_core_m;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.grant_id   = r_grant_id;

endmodule
`default_nettype wire
